// File: rtl/rmii_rx.sv
// RMII receive front end: strips preamble/SFD and forwards frame-body dibits
// with one cycle of latency, flagging clean ends, short/odd frames and jabber.
module rmii_rx #(
  parameter int PREAMBLE_MIN = 7,
  parameter int MAX_DIBITS   = 6072
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       frame_done,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  localparam logic [4:0]  PRE_MIN = 5'(PREAMBLE_MIN);
  localparam logic [12:0] MAX_CNT = 13'(MAX_DIBITS);

  state_t      state;
  logic [4:0]  pre_cnt;
  logic [12:0] dib_cnt;

  // Outputs default low each cycle so pulses last one cycle and axiod is 00 when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pre_cnt    <= '0;
      dib_cnt    <= '0;
      axiov      <= 1'b0;
      axiod      <= 2'b00;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      axiov      <= 1'b0;
      axiod      <= 2'b00;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          pre_cnt <= '0;
          dib_cnt <= '0;
          if (crsdv) begin
            if (rxd == 2'b01) begin
              state   <= PREAMBLE;
              pre_cnt <= 5'd1;
            end else begin
              state <= DROP;
            end
          end
        end
        PREAMBLE: begin
          if (!crsdv) begin
            state   <= IDLE;
            pre_cnt <= '0;
            dib_cnt <= '0;
          end else begin
            case (rxd)
              2'b01: if (pre_cnt != 5'd31) pre_cnt <= pre_cnt + 5'd1;
              2'b11: begin
                if (pre_cnt >= PRE_MIN) begin
                  state   <= DATA;
                  dib_cnt <= '0;
                end else begin
                  state <= DROP;
                end
              end
              default: state <= DROP;
            endcase
          end
        end
        DATA: begin
          if (crsdv) begin
            // A dibit beyond the maximum frame length is jabber: abort instead of forwarding.
            if (dib_cnt == MAX_CNT) begin
              frame_err <= 1'b1;
              state     <= DROP;
            end else begin
              axiov   <= 1'b1;
              axiod   <= rxd;
              dib_cnt <= dib_cnt + 13'd1;
            end
          end else begin
            if (dib_cnt != '0 && dib_cnt[1:0] == 2'b00) frame_done <= 1'b1;
            else                                         frame_err  <= 1'b1;
            state   <= IDLE;
            pre_cnt <= '0;
            dib_cnt <= '0;
          end
        end
        DROP: begin
          if (!crsdv) begin
            state   <= IDLE;
            pre_cnt <= '0;
            dib_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rmii_rx.md
RMII_RX -- requirements
Module: rmii_rx

Interface
REQ-001 SHALL have parameter PREAMBLE_MIN, default 7, meaning the minimum number of consecutive 2'b01 dibits that must precede the SFD dibit.
REQ-002 SHALL have parameter MAX_DIBITS, default 6072, meaning the maximum number of post-SFD dibits accepted per frame (1518 bytes).
REQ-003 SHALL have port clk, input, 1, the single 50 MHz RMII reference clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port crsdv, input, 1, RMII carrier-sense/data-valid.
REQ-006 SHALL have port rxd, input, 2, RMII receive dibit; rxd[0] is the earlier bit on the wire.
REQ-007 SHALL have port axiov, output, 1, frame-body dibit valid, feeding the downstream CRC-check stage.
REQ-008 SHALL have port axiod, output, 2, frame-body dibit in raw RMII order (rxd[0] first), with no bit swap.
REQ-009 SHALL have port frame_done, output, 1, one-cycle pulse marking the clean end of a forwarded frame.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse marking an aborted or malformed frame.

Function
REQ-011 SHALL implement the FSM states IDLE, PREAMBLE, DATA and DROP.
REQ-012 IDLE: crsdv=1 with rxd=01 -> PREAMBLE with pre_cnt=1; crsdv=1 with any other rxd -> DROP; crsdv=0 -> stay in IDLE.
REQ-013 PREAMBLE, rxd=01: increment pre_cnt, saturating at 31.
REQ-014 PREAMBLE, rxd=11 with pre_cnt>=PREAMBLE_MIN: go to DATA and clear dib_cnt; the SFD dibit is not forwarded.
REQ-015 PREAMBLE, rxd=11 with pre_cnt<PREAMBLE_MIN, or rxd in {00,10}: go to DROP; no frame_err is raised.
REQ-016 PREAMBLE, crsdv=0: go to IDLE silently.
REQ-017 DATA, crsdv=1: forward rxd and increment the 13-bit dib_cnt.
REQ-018 Forwarding SHALL register rxd so that axiov=1 and axiod=rxd appear exactly one cycle after sampling (fixed latency 1).
REQ-019 DATA, crsdv=1 with dib_cnt==MAX_DIBITS: do not forward the dibit, pulse frame_err, go to DROP (jabber).
REQ-020 DATA, crsdv=0 with dib_cnt a nonzero multiple of 4: pulse frame_done in the cycle after crsdv is sampled low, then go to IDLE.
REQ-021 DATA, crsdv=0 with dib_cnt==0 or not a multiple of 4: pulse frame_err instead of frame_done, then go to IDLE.
REQ-022 Whenever crsdv is sampled 0 in DATA, axiov SHALL be 0 the next cycle.
REQ-023 DROP: axiov SHALL stay 0; go to IDLE on the first cycle crsdv=0.
REQ-024 frame_done and frame_err SHALL never both be asserted, and each SHALL be high for exactly one cycle per event.
REQ-025 axiod SHALL be 2'b00 whenever axiov=0.
REQ-026 The block SHALL apply no backpressure; the downstream stage must accept one dibit per cycle.
REQ-027 pre_cnt and dib_cnt SHALL clear on every entry to IDLE.

Reset
REQ-028 rst=0 SHALL immediately force state=IDLE, pre_cnt=0, dib_cnt=0, axiov=0, axiod=00, frame_done=0 and frame_err=0, independent of clk.
REQ-029 Reset asserted mid-frame SHALL drop the frame with no frame_done or frame_err pulse.
REQ-030 After reset deassertion with crsdv already high, the block SHALL resynchronise via IDLE/DROP and never forward a partial frame.

Verification
REQ-031 Clean frame: 31x01, 11, 84 body dibits (21 bytes, including the 4 CRC bytes), crsdv low -> 84 axiov cycles with the same dibits, each one cycle late, then one frame_done pulse and no frame_err.
REQ-032 Short preamble: 5x01 then 11 -> DROP; axiov stays 0 and no pulses occur.
REQ-033 Odd end: 31x01, 11, 10 body dibits, crsdv low -> 10 valid dibits, then frame_err=1 for one cycle.
REQ-034 Jabber: 31x01, 11, 6073 body dibits -> exactly 6072 forwarded, frame_err on the 6073rd, axiov=0 until crsdv drops.
REQ-035 Reset: assert rst=0 at body dibit 40 of a frame -> all outputs 0 asynchronously, no pulses; the next clean frame is forwarded intact.
REQ-036 Back-to-back: two clean frames with one idle cycle between them -> two frame_done pulses and no dibits merged across frames.
